// File: rtl/tft_spi_stream.sv
// tft_spi_stream: TFT panel SPI controller.
// After reset it pulses the panel reset line, then walks an external init ROM
// (commands, parameters, millisecond delays, end marker). Once the END entry
// is processed it streams words from a valid/ready source. SCK is derived from
// MasterCLK by a fixed divider (SPI mode 0, MSB first).
//
// Ports:
//   MasterCLK  system clock
//   reset      synchronous, active-low reset
//   init_addr  init ROM address (ROM returns init_word one cycle later)
//   init_word  {type[1:0], payload}: 00 cmd, 01 data, 10 delay (ms), 11 end
//   s_valid / s_ready / s_data / s_dc  stream word handshake (s_dc: 1 data)
//   SPI_CLK, SPI_MOSI, SPI_CS  serial interface (CS active low)
//   RS         D/C line to the panel
//   RST        panel reset, active low
//   init_done  sticky, set once the init table has ended
//   busy       high whenever the controller is not idle in stream mode
module tft_spi_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 5,
  parameter int DELAY_UNIT = 50000,
  parameter int RST_LOW    = 500,
  parameter int RST_WAIT   = 6000000,
  parameter int ROM_AW     = 8
) (
  input  logic                  MasterCLK,
  input  logic                  reset,
  output logic [ROM_AW-1:0]     init_addr,
  input  logic [DATA_WIDTH+1:0] init_word,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_dc,
  output logic                  SPI_CLK,
  output logic                  SPI_MOSI,
  output logic                  SPI_CS,
  output logic                  RS,
  output logic                  RST,
  output logic                  init_done,
  output logic                  busy
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CNT_MAX = max2(max2(RST_LOW, RST_WAIT), max2(CLK_DIV, DELAY_UNIT));
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int HALF_W = $clog2(2 * DATA_WIDTH);

  typedef enum logic [2:0] {
    RST_PULSE,
    RST_HOLD,
    FETCH,
    DELAY,
    SHIFT,
    GAP,
    STREAM_IDLE
  } state_t;

  state_t                  state, stateNext;
  logic [CNT_W-1:0]        cnt, cntNext;
  logic [HALF_W-1:0]       half, halfNext;
  logic [DATA_WIDTH-1:0]   msLeft, msLeftNext;
  logic [DATA_WIDTH-1:0]   shreg, shregNext;
  logic [ROM_AW-1:0]       addr, addrNext;
  logic                    sck, sckNext;
  logic                    mosi, mosiNext;
  logic                    cs, csNext;
  logic                    rs, rsNext;
  logic                    rst, rstNext;
  logic                    done, doneNext;
  logic                    fetchWait, fetchWaitNext;

  logic                    loadShift;
  logic [DATA_WIDTH-1:0]   loadWord;
  logic                    loadDc;

  logic [1:0]              wordType;
  logic [DATA_WIDTH-1:0]   payload;

  assign wordType = init_word[DATA_WIDTH+1:DATA_WIDTH];
  assign payload  = init_word[DATA_WIDTH-1:0];

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    halfNext      = half;
    msLeftNext    = msLeft;
    shregNext     = shreg;
    addrNext      = addr;
    sckNext       = sck;
    mosiNext      = mosi;
    csNext        = cs;
    rsNext        = rs;
    rstNext       = rst;
    doneNext      = done;
    fetchWaitNext = fetchWait;
    loadShift     = 1'b0;
    loadWord      = '0;
    loadDc        = 1'b0;

    unique case (state)
      RST_PULSE: begin
        if (cnt == CNT_W'(RST_LOW - 1)) begin
          stateNext = RST_HOLD;
          cntNext   = '0;
          rstNext   = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      RST_HOLD: begin
        // Address 0 has been stable since reset, so the first fetch needs
        // no ROM wait cycle.
        if (cnt == CNT_W'(RST_WAIT - 1)) begin
          stateNext     = FETCH;
          cntNext       = '0;
          fetchWaitNext = 1'b0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      FETCH: begin
        if (fetchWait) begin
          fetchWaitNext = 1'b0;
        end else if (addr == '1 || wordType == 2'b11) begin
          // Last ROM slot is an implicit END so the walk cannot wrap.
          stateNext = STREAM_IDLE;
          doneNext  = 1'b1;
        end else if (wordType == 2'b10) begin
          stateNext  = DELAY;
          cntNext    = '0;
          msLeftNext = payload;
        end else begin
          loadShift = 1'b1;
          loadWord  = payload;
          loadDc    = wordType[0];
        end
      end

      DELAY: begin
        // Two-level count (cycles per ms, then ms) covers the full
        // payload*DELAY_UNIT range without a wide multiplier.
        if (msLeft == '0) begin
          stateNext     = FETCH;
          addrNext      = addr + ROM_AW'(1);
          fetchWaitNext = 1'b1;
        end else if (cnt == CNT_W'(DELAY_UNIT - 1)) begin
          cntNext = '0;
          if (msLeft == DATA_WIDTH'(1)) begin
            stateNext     = FETCH;
            addrNext      = addr + ROM_AW'(1);
            fetchWaitNext = 1'b1;
          end else begin
            msLeftNext = msLeft - DATA_WIDTH'(1);
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cntNext  = '0;
          sckNext  = ~sck;
          halfNext = half + HALF_W'(1);
          if (sck) begin
            // Falling edge: either the word is complete or the next bit goes out.
            if (half == HALF_W'(2 * DATA_WIDTH - 1)) begin
              stateNext = GAP;
              csNext    = 1'b1;
              mosiNext  = 1'b0;
            end else begin
              shregNext = shreg << 1;
              mosiNext  = shreg[DATA_WIDTH-2];
            end
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cntNext = '0;
          if (done) begin
            stateNext = STREAM_IDLE;
          end else begin
            stateNext     = FETCH;
            addrNext      = addr + ROM_AW'(1);
            fetchWaitNext = 1'b1;
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      STREAM_IDLE: begin
        if (s_valid) begin
          loadShift = 1'b1;
          loadWord  = s_data;
          loadDc    = s_dc;
        end
      end

      default: begin
        stateNext = RST_PULSE;
      end
    endcase

    if (loadShift) begin
      stateNext = SHIFT;
      csNext    = 1'b0;
      sckNext   = 1'b0;
      mosiNext  = loadWord[DATA_WIDTH-1];
      shregNext = loadWord;
      rsNext    = loadDc;
      cntNext   = '0;
      halfNext  = '0;
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (!reset) begin
      state     <= RST_PULSE;
      cnt       <= '0;
      half      <= '0;
      msLeft    <= '0;
      shreg     <= '0;
      addr      <= '0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      cs        <= 1'b1;
      rs        <= 1'b0;
      rst       <= 1'b0;
      done      <= 1'b0;
      fetchWait <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      half      <= halfNext;
      msLeft    <= msLeftNext;
      shreg     <= shregNext;
      addr      <= addrNext;
      sck       <= sckNext;
      mosi      <= mosiNext;
      cs        <= csNext;
      rs        <= rsNext;
      rst       <= rstNext;
      done      <= doneNext;
      fetchWait <= fetchWaitNext;
    end
  end

  assign init_addr = addr;
  assign SPI_CLK   = sck;
  assign SPI_MOSI  = mosi;
  assign SPI_CS    = cs;
  assign RS        = rs;
  assign RST       = rst;
  assign init_done = done;
  assign s_ready   = (state == STREAM_IDLE);
  assign busy      = (state != STREAM_IDLE);

endmodule

// File: tb/tb_tft_spi_stream.sv
// Bench for tft_spi_stream: builds the expected per-cycle output timeline from
// the ROM contents and the planned stream traffic, then compares every cycle.
// A serial decoder additionally collects the words seen on the wire.
module tb_tft_spi_stream;
  localparam int DW = 8;
  localparam int CD = 2;
  localparam int DU = 10;
  localparam int RL = 4;
  localparam int RW = 8;
  localparam int NC = 512;

  logic          MasterCLK = 1'b0;
  logic          reset;
  logic [7:0]    init_addr;
  logic [DW+1:0] init_word;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_dc;
  logic          SPI_CLK, SPI_MOSI, SPI_CS, RS, RST, init_done, busy;

  tft_spi_stream #(
    .DATA_WIDTH(DW), .CLK_DIV(CD), .DELAY_UNIT(DU),
    .RST_LOW(RL), .RST_WAIT(RW), .ROM_AW(8)
  ) dut (
    .MasterCLK(MasterCLK), .reset(reset), .init_addr(init_addr),
    .init_word(init_word), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_dc(s_dc), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_CS(SPI_CS), .RS(RS), .RST(RST), .init_done(init_done), .busy(busy)
  );

  always #5 MasterCLK = ~MasterCLK;

  int cyc = 0;
  always @(posedge MasterCLK) cyc <= cyc + 1;

  logic [DW+1:0] rom [0:255];
  always @(posedge MasterCLK) init_word <= rom[init_addr];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- expected timeline ----------------
  typedef struct {
    logic rst, cs, sck, mosi, mchk, rs, rchk, ready, done, achk;
    logic [7:0] addr;
  } exp_t;
  exp_t em [0:NC-1];
  int   tc;
  int   curAddr;
  logic curDone;
  bit   modelReady = 0;
  int   endCyc;

  task automatic setEm(input logic rst, cs, sck, mosi, mchk, rs, rchk, ready);
    em[tc] = '{rst: rst, cs: cs, sck: sck, mosi: mosi, mchk: mchk, rs: rs,
               rchk: rchk, ready: ready, done: curDone, achk: !curDone,
               addr: curAddr[7:0]};
    tc++;
  endtask

  task automatic put(input int n, input logic rst, input logic cs, input logic ready);
    for (int i = 0; i < n; i++) setEm(rst, cs, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ready);
  endtask

  task automatic shiftW(input logic [DW-1:0] w, input logic dc, input int len);
    for (int j = 0; j < len; j++)
      setEm(1'b1, 1'b0, 1'((j / CD) % 2), w[DW-1-(j/(2*CD))], 1'b1, dc, 1'b1, 1'b0);
  endtask

  task automatic gapW(input logic dc);
    for (int j = 0; j < CD; j++) setEm(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, dc, 1'b1, 1'b0);
  endtask

  task automatic initSeq(input int extraReset);
    logic [DW+1:0] e;
    bit first;
    curDone = 1'b0;
    curAddr = 0;
    put(extraReset + RL, 1'b0, 1'b1, 1'b0);
    put(RW, 1'b1, 1'b1, 1'b0);
    first = 1;
    for (int k = 0; k < 256; k++) begin
      put(first ? 1 : 2, 1'b1, 1'b1, 1'b0);
      first = 0;
      e = rom[curAddr];
      if (e[DW+1:DW] == 2'b11 || curAddr == 255) begin
        curDone = 1'b1;
        break;
      end else if (e[DW+1:DW] == 2'b10) begin
        put((e[DW-1:0] == 0) ? 1 : int'(e[DW-1:0]) * DU, 1'b1, 1'b1, 1'b0);
        curAddr++;
      end else begin
        shiftW(e[DW-1:0], e[DW], 2 * DW * CD);
        gapW(e[DW]);
        curAddr++;
      end
    end
  endtask

  task automatic streamWord(input logic dc, input logic [DW-1:0] w);
    put(1, 1'b1, 1'b1, 1'b1);
    shiftW(w, dc, 2 * DW * CD);
    gapW(dc);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge MasterCLK) begin
    if (modelReady && cyc >= 1 && cyc < endCyc) begin
      exp_t e;
      logic [15:0] act, exv;
      e = em[cyc];
      act = {RST, SPI_CS, SPI_CLK, e.mchk ? SPI_MOSI : 1'b0, e.rchk ? RS : 1'b0,
             s_ready, busy, init_done, e.achk ? init_addr : 8'h00};
      exv = {e.rst, e.cs, e.sck, e.mchk ? e.mosi : 1'b0, e.rchk ? e.rs : 1'b0,
             e.ready, !e.ready, e.done, e.achk ? e.addr : 8'h00};
      chk($sformatf("cyc%0d rst,cs,sck,mosi,rs,rdy,busy,done,addr", cyc), 32'(act), 32'(exv));
    end
  end

  // ---------------- serial decoder ----------------
  typedef struct { logic dc; logic [7:0] bits; int nb; } rx_t;
  rx_t  rxQ[$];
  logic pSck = 1'b0, pCs = 1'b1, curRs = 1'b0;
  logic [7:0] bits = '0;
  int   nb = 0;
  int   firstCsLow = 0;
  int   rstLowCnt = 0;

  always @(negedge MasterCLK) begin
    if (cyc >= 1) begin
      if (!SPI_CS && SPI_CLK && !pSck) begin
        bits = {bits[6:0], SPI_MOSI};
        nb++;
        curRs = RS;
      end
      if (SPI_CS && !pCs) begin
        rxQ.push_back('{dc: curRs, bits: bits, nb: nb});
        bits = '0;
        nb = 0;
      end
      if (!SPI_CS && firstCsLow == 0) firstCsLow = cyc;
      if (cyc >= 2 && cyc <= 20 && RST == 1'b0) rstLowCnt++;
      pSck = SPI_CLK;
      pCs = SPI_CS;
    end
  end

  // ---------------- stimulus ----------------
  task automatic waitCyc(input int c);
    while (cyc < c) @(negedge MasterCLK);
  endtask

  task automatic send(input logic dc, input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    s_valid = 1'b1;
    s_data = d;
    s_dc = dc;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (s_ready) ok = 1;
      @(negedge MasterCLK);
    end
    s_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL handshake %h: got no s_ready expected s_ready within 200 cycles", d);
    end
  endtask

  int pA, pB, pC, rC;
  logic [7:0] eb [7] = '{8'hA5, 8'h3C, 8'h81, 8'h7E, 8'hC3, 8'h07, 8'hA5};
  int         en [7] = '{8, 8, 8, 8, 8, 3, 8};
  logic       ed [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    reset = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_dc = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = {2'b11, 8'h00};
    rom[0] = {2'b00, 8'hA5};
    rom[1] = {2'b10, 8'd3};
    rom[2] = {2'b11, 8'h00};

    // cyc 1 follows an extra reset edge; cyc 2 is the first RST_PULSE cycle.
    tc = 1;
    initSeq(1);
    pA = tc + 2;
    put(pA - tc, 1'b1, 1'b1, 1'b1);
    streamWord(1'b1, 8'h3C);
    pB = tc + 2;
    put(2, 1'b1, 1'b1, 1'b1);
    streamWord(1'b0, 8'h81);
    streamWord(1'b1, 8'h7E);
    streamWord(1'b1, 8'hC3);
    pC = tc + 8;
    put(8, 1'b1, 1'b1, 1'b1);
    put(1, 1'b1, 1'b1, 1'b1);
    shiftW(8'hF0, 1'b1, 13);
    rC = tc - 1;
    initSeq(0);
    put(10, 1'b1, 1'b1, 1'b1);
    endCyc = tc;
    modelReady = 1;

    waitCyc(2);
    reset = 1'b1;
    waitCyc(pA);
    send(1'b1, 8'h3C);
    waitCyc(pB);
    send(1'b0, 8'h81);
    send(1'b1, 8'h7E);
    send(1'b1, 8'hC3);
    waitCyc(pC);
    send(1'b1, 8'hF0);
    waitCyc(rC);
    reset = 1'b0;
    @(negedge MasterCLK);
    reset = 1'b1;
    waitCyc(endCyc);

    // Hand-computed anchors for the model.
    chk("timeline_end", 32'(endCyc), 32'd340);
    chk("first_cs_low_cycle", 32'(firstCsLow), 32'd15);
    chk("rst_low_cycles", 32'(rstLowCnt), 32'd4);
    chk("rx_word_count", 32'(rxQ.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < rxQ.size()) begin
        chk($sformatf("rx%0d dc,bits,nb", i), {23'(0), rxQ[i].dc, rxQ[i].bits},
            {23'(0), ed[i], eb[i]});
        chk($sformatf("rx%0d nb", i), 32'(rxQ[i].nb), 32'(en[i]));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
